// File: rtl/uart_tx_ctrl.sv
// Transmit-side sequencer for the UART TX path: walks the output mux through
// start, LSB-first data, optional parity and stop bit periods, each CLKS_PER_BIT long.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic [1:0]        select,
  output logic              data_bit,
  output logic              parity_bit,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned CW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(DATA_W - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state, state_n;
  logic [BW-1:0]     baud, baud_n;
  logic [CW-1:0]     bitc, bitc_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic              par_en, par_en_n;
  logic              parity_n, busy_n, done_n, data_bit_n;
  logic [1:0]        select_n;
  logic              baud_end;

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud       <= '0;
      bitc       <= '0;
      shreg      <= '0;
      par_en     <= 1'b0;
      select     <= 2'd3;
      data_bit   <= 1'b0;
      parity_bit <= 1'b0;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bitc       <= bitc_n;
      shreg      <= shreg_n;
      par_en     <= par_en_n;
      select     <= select_n;
      data_bit   <= data_bit_n;
      parity_bit <= parity_n;
      tx_busy    <= busy_n;
      tx_done    <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    baud_n   = baud;
    bitc_n   = bitc;
    shreg_n  = shreg;
    par_en_n = par_en;
    parity_n = parity_bit;
    busy_n   = tx_busy;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (tx_start) begin
          shreg_n  = tx_data;
          par_en_n = parity_en;
          parity_n = ^tx_data ^ parity_odd;
          busy_n   = 1'b1;
          baud_n   = '0;
          bitc_n   = '0;
          state_n  = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n  = '0;
          shreg_n = shreg >> 1;
          if (bitc == BIT_LAST) begin
            bitc_n  = '0;
            state_n = par_en ? PARITY : STOP;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      PARITY: begin
        if (baud_end) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        // Bit counter is reused to count stop bit periods.
        if (baud_end) begin
          baud_n = '0;
          if (bitc == STOP_LAST) begin
            bitc_n  = '0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            bitc_n = bitc + 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    select_n   = 2'd3;
    data_bit_n = shreg_n[0];
    unique case (state_n)
      START:   select_n = 2'd0;
      DATA:    select_n = 2'd1;
      PARITY:  select_n = 2'd2;
      default: select_n = 2'd3;
    endcase
  end

endmodule
